mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port 256x8 memory unit between the CPU and a program loader/DMA requester.
- Accepts req/gnt transactions on each port and issues exactly one memory access at a time.
- Drives the memory's we/addr/data_in and returns read data with a valid strobe to the owning port.
- Sits between the cpu core, the loader and the memory instance. Arbitration is round-robin, or CPU-priority with a starvation guard.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   - default address/data widths
//   - FSM state encoding (IDLE/ISSUE/CAPTURE, 2 bits)
//   - requester port IDs (CPU = 0, loader = 1)
//   - width of the loader starvation counter (limits 1..15)
package mem_arb_pkg;

    localparam int unsigned DefAddrW   = 8;
    localparam int unsigned DefDataW   = 8;
    localparam int unsigned StarveCntW = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2
    } state_e;

    typedef enum logic {
        PortCpu = 1'b0,
        PortLdr = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU, the loader, the arbiter and the 256x8 memory.
//   cpu_* / ldr_* : req/we/addr/wdata from requesters, gnt/rvalid/rdata back
//   mem_*         : we/addr/wdata to the memory, rdata (synchronous) back
//   busy          : arbiter has an access in ISSUE or CAPTURE
// Modports: slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::DefAddrW,
    parameter int unsigned DATA_W = mem_arb_pkg::DefDataW
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational two-way picker.
//   cpu_req_i, ldr_req_i : pending requests
//   rr_last_i            : previous winner (round-robin mode)
//   starve_cnt_i         : consecutive loader losses (CPU-priority mode)
//   winner_o, valid_o    : selected port, and whether anyone requested
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit          CPU_PRIO     = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  cpu_req_i,
    input  logic                  ldr_req_i,
    input  port_e                 rr_last_i,
    input  logic [StarveCntW-1:0] starve_cnt_i,
    output port_e                 winner_o,
    output logic                  valid_o
);

    localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE_LIMIT);

    always_comb begin
        valid_o  = cpu_req_i | ldr_req_i;
        winner_o = PortCpu;
        if (cpu_req_i && ldr_req_i) begin
            if (CPU_PRIO) begin
                // Loader gets one access once it has lost STARVE_LIMIT times in a row.
                winner_o = (starve_cnt_i == StarveMax) ? PortLdr : PortCpu;
            end else begin
                winner_o = (rr_last_i == PortCpu) ? PortLdr : PortCpu;
            end
        end else if (ldr_req_i) begin
            winner_o = PortLdr;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read memory.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : slave view of mem_arbiter_if (CPU port, loader port,
//                  memory port, busy)
// One access at a time: IDLE samples requests, ISSUE presents the access
// to the memory for one cycle (gnt high), CAPTURE (reads only) latches
// mem_rdata into the owner's rdata, with rvalid in the following cycle.
// Every output comes straight from a register.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter bit          CPU_PRIO     = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);

    localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE_LIMIT);

    state_e                state_q;
    port_e                 owner_q;
    port_e                 rr_last_q;
    logic [StarveCntW-1:0] starve_cnt_q;

    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic                  busy_q;
    logic                  cpu_gnt_q;
    logic                  ldr_gnt_q;
    logic                  cpu_rvalid_q;
    logic                  ldr_rvalid_q;
    logic [DATA_W-1:0]     cpu_rdata_q;
    logic [DATA_W-1:0]     ldr_rdata_q;

    port_e                 winner;
    logic                  pick_valid;

    arb_pick #(
        .CPU_PRIO     (CPU_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_pick (
        .cpu_req_i    (bus.cpu_req),
        .ldr_req_i    (bus.ldr_req),
        .rr_last_i    (rr_last_q),
        .starve_cnt_i (starve_cnt_q),
        .winner_o     (winner),
        .valid_o      (pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= PortCpu;
            rr_last_q    <= PortLdr;  // first tie goes to the CPU
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            ldr_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            // gnt and rvalid are single-cycle pulses.
            cpu_gnt_q    <= 1'b0;
            ldr_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!bus.ldr_req || (winner == PortLdr)) begin
                        starve_cnt_q <= '0;
                    end else if (starve_cnt_q != StarveMax) begin
                        starve_cnt_q <= starve_cnt_q + 1'b1;
                    end

                    if (pick_valid) begin
                        owner_q   <= winner;
                        rr_last_q <= winner;
                        busy_q    <= 1'b1;
                        state_q   <= StIssue;
                        if (winner == PortCpu) begin
                            mem_we_q    <= bus.cpu_we;
                            mem_addr_q  <= bus.cpu_addr;
                            mem_wdata_q <= bus.cpu_wdata;
                            cpu_gnt_q   <= 1'b1;
                        end else begin
                            mem_we_q    <= bus.ldr_we;
                            mem_addr_q  <= bus.ldr_addr;
                            mem_wdata_q <= bus.ldr_wdata;
                            ldr_gnt_q   <= 1'b1;
                        end
                    end
                end

                StIssue: begin
                    // The memory samples the access at this edge.
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StCapture;
                    end
                end

                StCapture: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (owner_q == PortCpu) begin
                        cpu_rdata_q  <= bus.mem_rdata;
                        cpu_rvalid_q <= 1'b1;
                    end else begin
                        ldr_rdata_q  <= bus.mem_rdata;
                        ldr_rvalid_q <= 1'b1;
                    end
                end

                default: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ldr_gnt    = ldr_gnt_q;
    assign bus.ldr_rvalid = ldr_rvalid_q;
    assign bus.ldr_rdata  = ldr_rdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a CPU-priority instance (STARVE_LIMIT=4) backed by
// a 256x8 synchronous memory, and a round-robin instance backed by a ROM.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ifp ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ifr ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CPU_PRIO(1'b1), .STARVE_LIMIT(4)) dut_p (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifp)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CPU_PRIO(1'b0), .STARVE_LIMIT(4)) dut_r (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifr)
    );

    // 256x8 memory, synchronous read.
    logic [7:0] mem_p [256];
    always @(posedge clk) begin
        if (ifp.mem_we) mem_p[ifp.mem_addr] <= ifp.mem_wdata;
        ifp.mem_rdata <= mem_p[ifp.mem_addr];
    end

    // Round-robin instance only reads: a ROM returning addr + 0x40.
    always @(posedge clk) ifr.mem_rdata <= ifr.mem_addr + 8'h40;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Scoreboard for dut_p: expected grants in order, then expected read returns.
    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;

    exp_t gq[$];
    rd_t  rq_cpu[$];
    rd_t  rq_ldr[$];
    exp_t mon_e;
    rd_t  mon_r;
    logic [7:0] exp_cpu_rd = 8'h00;
    logic [7:0] exp_ldr_rd = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            // Accesses in flight at reset are abandoned.
            rq_cpu.delete();
            rq_ldr.delete();
            exp_cpu_rd = 8'h00;
            exp_ldr_rd = 8'h00;
        end else begin
            if (ifp.cpu_gnt && ifp.ldr_gnt) fail("gnt_both");
            if (ifp.cpu_gnt || ifp.ldr_gnt) begin
                if (gq.size() == 0) begin
                    fail("gnt_unexpected");
                end else begin
                    mon_e = gq.pop_front();
                    check("gnt_port", int'(ifp.ldr_gnt), int'(mon_e.port));
                    check("mem_we", int'(ifp.mem_we), int'(mon_e.we));
                    check("mem_addr", int'(ifp.mem_addr), int'(mon_e.addr));
                    check("busy_issue", int'(ifp.busy), 1);
                    if (mon_e.we) begin
                        check("mem_wdata", int'(ifp.mem_wdata), int'(mon_e.wdata));
                    end else begin
                        mon_r.data = mon_e.rdata;
                        mon_r.due  = cyc + 2;
                        if (mon_e.port) rq_ldr.push_back(mon_r);
                        else rq_cpu.push_back(mon_r);
                    end
                end
            end else begin
                check("mem_we_idle", int'(ifp.mem_we), 0);
            end

            if (ifp.cpu_rvalid) begin
                if (rq_cpu.size() == 0) begin
                    fail("cpu_rvalid_unexpected");
                end else begin
                    mon_r = rq_cpu.pop_front();
                    check("cpu_rvalid_cycle", cyc, mon_r.due);
                    check("cpu_rdata", int'(ifp.cpu_rdata), int'(mon_r.data));
                    exp_cpu_rd = mon_r.data;
                end
            end
            if (ifp.ldr_rvalid) begin
                if (rq_ldr.size() == 0) begin
                    fail("ldr_rvalid_unexpected");
                end else begin
                    mon_r = rq_ldr.pop_front();
                    check("ldr_rvalid_cycle", cyc, mon_r.due);
                    check("ldr_rdata", int'(ifp.ldr_rdata), int'(mon_r.data));
                    exp_ldr_rd = mon_r.data;
                end
            end
            if (rq_cpu.size() > 0 && rq_cpu[0].due < cyc) begin
                fail("cpu_rvalid_missing");
                void'(rq_cpu.pop_front());
            end
            if (rq_ldr.size() > 0 && rq_ldr[0].due < cyc) begin
                fail("ldr_rvalid_missing");
                void'(rq_ldr.pop_front());
            end
            check("cpu_rdata_hold", int'(ifp.cpu_rdata), int'(exp_cpu_rd));
            check("ldr_rdata_hold", int'(ifp.ldr_rdata), int'(exp_ldr_rd));
        end
    end

    // Raise one request, expect its grant, drop req on the grant cycle.
    task automatic do_txn(input logic p, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdata, output int gcyc);
        exp_t e;
        e.port  = p;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = rdata;
        gq.push_back(e);
        if (p) begin
            ifp.ldr_we = we; ifp.ldr_addr = addr; ifp.ldr_wdata = wdata; ifp.ldr_req = 1'b1;
        end else begin
            ifp.cpu_we = we; ifp.cpu_addr = addr; ifp.cpu_wdata = wdata; ifp.cpu_req = 1'b1;
        end
        gcyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((p ? ifp.ldr_gnt : ifp.cpu_gnt) == 1'b1) begin
                gcyc = cyc;
                break;
            end
        end
        ifp.cpu_req = 1'b0;
        ifp.ldr_req = 1'b0;
        if (gcyc < 0) fail("gnt_timeout");
    endtask

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         gap;    // expected cycles since previous grant, 0 = unchecked
    } vec_t;

    vec_t vecs[11];

    initial begin
        int gcyc;
        int prev;
        int n;
        int nrv;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gcyc;
        int prev;
        int n;
        int nrv;

        vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 0};
        vecs[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 2};
        vecs[2]  = '{1'b1, 1'b1, 8'h00, 8'h20, 8'h00, 3};
        vecs[3]  = '{1'b1, 1'b1, 8'h01, 8'h41, 8'h00, 2};
        vecs[4]  = '{1'b1, 1'b1, 8'h02, 8'hE0, 8'h00, 2};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h20, 2};
        vecs[6]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h41, 3};
        vecs[7]  = '{1'b0, 1'b0, 8'h02, 8'h00, 8'hE0, 3};
        vecs[8]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 3};
        vecs[9]  = '{1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00, 3};
        vecs[10] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, 2};

        ifp.cpu_req = 0; ifp.cpu_we = 0; ifp.cpu_addr = 0; ifp.cpu_wdata = 0;
        ifp.ldr_req = 0; ifp.ldr_we = 0; ifp.ldr_addr = 0; ifp.ldr_wdata = 0;
        ifr.cpu_req = 0; ifr.cpu_we = 0; ifr.cpu_addr = 0; ifr.cpu_wdata = 0;
        ifr.ldr_req = 0; ifr.ldr_we = 0; ifr.ldr_addr = 0; ifr.ldr_wdata = 0;

        // Reset state
        #1;
        check("rst_cpu_gnt", int'(ifp.cpu_gnt), 0);
        check("rst_ldr_gnt", int'(ifp.ldr_gnt), 0);
        check("rst_rvalid", int'({ifp.cpu_rvalid, ifp.ldr_rvalid}), 0);
        check("rst_mem_we", int'(ifp.mem_we), 0);
        check("rst_busy", int'(ifp.busy), 0);
        check("rst_mem_addr", int'(ifp.mem_addr), 0);
        check("rst_mem_wdata", int'(ifp.mem_wdata), 0);
        check("rst_rdata", int'({ifp.cpu_rdata, ifp.ldr_rdata}), 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Single-requester table: CPU write/read, loader preload, CPU fetch.
        prev = 0;
        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, gcyc);
            if (i > 0 && vecs[i].gap != 0) check("gnt_gap", gcyc - prev, vecs[i].gap);
            prev = gcyc;
        end
        repeat (4) @(negedge clk);

        // Round-robin instance: both held, CPU first, then alternate.
        ifr.cpu_addr = 8'h01;
        ifr.ldr_addr = 8'h02;
        ifr.cpu_req  = 1'b1;
        ifr.ldr_req  = 1'b1;
        n = 0;
        nrv = 0;
        for (int k = 0; k < 60 && nrv < 6; k++) begin
            @(negedge clk);
            if (ifr.cpu_gnt && ifr.ldr_gnt) fail("rr_gnt_both");
            if (ifr.cpu_gnt || ifr.ldr_gnt) begin
                check("rr_port", int'(ifr.ldr_gnt), n % 2);
                check("rr_addr", int'(ifr.mem_addr), (n % 2 == 1) ? 2 : 1);
                n++;
                if (n == 6) begin
                    ifr.cpu_req = 1'b0;
                    ifr.ldr_req = 1'b0;
                end
            end
            if (ifr.cpu_rvalid) begin
                check("rr_cpu_rdata", int'(ifr.cpu_rdata), 8'h41);
                nrv++;
            end
            if (ifr.ldr_rvalid) begin
                check("rr_ldr_rdata", int'(ifr.ldr_rdata), 8'h42);
                nrv++;
            end
            if (ifr.mem_we) fail("rr_mem_we");
        end
        ifr.cpu_req = 1'b0;
        ifr.ldr_req = 1'b0;
        check("rr_grants", n, 6);
        check("rr_rvalids", nrv, 6);

        // Starvation guard: CPU x4, loader x1, repeated.
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.port  = (i % 5 == 4);
            e.we    = 1'b0;
            e.addr  = e.port ? 8'h02 : 8'h10;
            e.wdata = 8'h00;
            e.rdata = e.port ? 8'hE0 : 8'hA5;
            gq.push_back(e);
        end
        ifp.cpu_we = 1'b0; ifp.cpu_addr = 8'h10;
        ifp.ldr_we = 1'b0; ifp.ldr_addr = 8'h02;
        ifp.cpu_req = 1'b1;
        ifp.ldr_req = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 10; k++) begin
            @(negedge clk);
            if (ifp.cpu_gnt || ifp.ldr_gnt) n++;
        end
        ifp.cpu_req = 1'b0;
        ifp.ldr_req = 1'b0;
        check("starve_grants", n, 10);
        repeat (5) @(negedge clk);

        // Withdrawn loader request while the CPU owns ISSUE.
        do_txn(1'b0, 1'b0, 8'h01, 8'h00, 8'h41, gcyc);
        ifp.ldr_we = 1'b1; ifp.ldr_addr = 8'h99; ifp.ldr_wdata = 8'h66;
        ifp.ldr_req = 1'b1;
        @(negedge clk);
        ifp.ldr_req = 1'b0;
        repeat (4) @(negedge clk);
        check("withdraw_mem_addr", int'(ifp.mem_addr), 8'h01);

        // Async reset during CAPTURE of a CPU read.
        do_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, gcyc);
        @(posedge clk);
        #2;
        check("busy_capture", int'(ifp.busy), 1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", int'(ifp.busy), 0);
        check("arst_mem_we", int'(ifp.mem_we), 0);
        check("arst_gnt", int'({ifp.cpu_gnt, ifp.ldr_gnt}), 0);
        check("arst_rvalid", int'({ifp.cpu_rvalid, ifp.ldr_rvalid}), 0);
        check("arst_cpu_rdata", int'(ifp.cpu_rdata), 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        do_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, gcyc);
        repeat (4) @(negedge clk);

        // Async reset during ISSUE of a write: mem_we drops without a clock edge.
        do_txn(1'b0, 1'b1, 8'h30, 8'h77, 8'h00, gcyc);
        #1;
        check("wr_issue_mem_we", int'(ifp.mem_we), 1);
        reset_n = 1'b0;
        #1;
        check("arst_wr_mem_we", int'(ifp.mem_we), 0);
        check("arst_wr_gnt", int'(ifp.cpu_gnt), 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        do_txn(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, gcyc);
        repeat (5) @(negedge clk);

        check("gq_empty", gq.size(), 0);
        check("rq_empty", rq_cpu.size() + rq_ldr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
